// File: rtl/l1_latency_memory_module.sv
// Byte-masked word memory with independent read/write ports and a programmable access latency.
// Optional read-during-write forwarding is enabled by defining L1_MEM_RDW_BYPASS_EN.
module l1_latency_memory_module #(
    parameter int LOGICAL_ADD_WIDTH = 12,
    parameter int DATA_WIDTH        = 32,
    parameter int READ_LATENCY      = 2,
    parameter int WRITE_LATENCY     = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    read_en,
    input  logic [31:0]             read_addr,
    input  logic                    write_en,
    input  logic [31:0]             write_addr,
    input  logic [DATA_WIDTH/8-1:0] write_mask,
    input  logic [DATA_WIDTH-1:0]   write_data,
    output logic [DATA_WIDTH-1:0]   read_data,
    output logic                    stall
);
    localparam int BYTES   = DATA_WIDTH / 8;
    localparam int OFFS    = $clog2(BYTES);
    localparam int WORD_AW = LOGICAL_ADD_WIDTH - OFFS;
    localparam int DEPTH   = 1 << WORD_AW;
    localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CNT_W   = (MAX_LAT > 0) ? $clog2(MAX_LAT + 1) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                r_state, w_state_nxt;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
    logic                  r_rd_en, r_wr_en;
    logic [WORD_AW-1:0]    r_rd_word, r_wr_word;
    logic [BYTES-1:0]      r_wr_mask;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [DATA_WIDTH-1:0] r_rd_hold;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_latch, w_complete;
    logic [31:0]           w_lat;
    logic                  w_busy, w_rd_en, w_wr_en;
    logic [WORD_AW-1:0]    w_rd_word, w_wr_word;
    logic [BYTES-1:0]      w_wr_mask;
    logic [DATA_WIDTH-1:0] w_wr_data, w_mem_rdata, w_rd_value;
    logic                  w_unused_addr;

    // Only the word-select field of each address is decoded; the rest aliases.
    assign w_unused_addr = ^{read_addr, write_addr};

    always_comb begin
        w_lat = 32'd0;
        if (read_en && write_en) w_lat = 32'(MAX_LAT);
        else if (read_en)        w_lat = 32'(READ_LATENCY);
        else if (write_en)       w_lat = 32'(WRITE_LATENCY);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_latch     = 1'b0;
        w_complete  = 1'b0;
        stall       = 1'b0;
        case (r_state)
            IDLE: begin
                if (read_en || write_en) begin
                    if (w_lat == 32'd0) begin
                        w_complete = 1'b1;
                    end else begin
                        stall       = 1'b1;
                        w_latch     = 1'b1;
                        w_cnt_nxt   = CNT_W'(w_lat - 32'd1);
                        w_state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                if (r_cnt != '0) begin
                    stall     = 1'b1;
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_complete  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Zero-latency requests complete from the live inputs; otherwise from the latched copy.
    assign w_busy    = (r_state == BUSY);
    assign w_rd_en   = w_busy ? r_rd_en   : read_en;
    assign w_wr_en   = w_busy ? r_wr_en   : write_en;
    assign w_rd_word = w_busy ? r_rd_word : read_addr[LOGICAL_ADD_WIDTH-1:OFFS];
    assign w_wr_word = w_busy ? r_wr_word : write_addr[LOGICAL_ADD_WIDTH-1:OFFS];
    assign w_wr_mask = w_busy ? r_wr_mask : write_mask;
    assign w_wr_data = w_busy ? r_wr_data : write_data;

    assign w_mem_rdata = r_mem[w_rd_word];

`ifdef L1_MEM_RDW_BYPASS_EN
    always_comb begin
        w_rd_value = w_mem_rdata;
        if (w_wr_en && (w_wr_word == w_rd_word)) begin
            for (int b = 0; b < BYTES; b++) begin
                if (w_wr_mask[b]) w_rd_value[b*8 +: 8] = w_wr_data[b*8 +: 8];
            end
        end
    end
`else
    assign w_rd_value = w_mem_rdata;
`endif

    assign read_data = (w_complete && w_rd_en) ? w_rd_value : r_rd_hold;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_rd_en   <= 1'b0;
            r_wr_en   <= 1'b0;
            r_rd_word <= '0;
            r_wr_word <= '0;
            r_wr_mask <= '0;
            r_wr_data <= '0;
            r_rd_hold <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_latch) begin
                r_rd_en   <= read_en;
                r_wr_en   <= write_en;
                r_rd_word <= read_addr[LOGICAL_ADD_WIDTH-1:OFFS];
                r_wr_word <= write_addr[LOGICAL_ADD_WIDTH-1:OFFS];
                r_wr_mask <= write_mask;
                r_wr_data <= write_data;
            end
            if (w_complete && w_rd_en) r_rd_hold <= w_rd_value;
        end
    end

    // Array is deliberately left unreset; reset only suppresses a pending commit.
    always_ff @(posedge clk) begin
        if (w_complete && w_wr_en && !reset) begin
            for (int b = 0; b < BYTES; b++) begin
                if (w_wr_mask[b]) r_mem[w_wr_word][b*8 +: 8] <= w_wr_data[b*8 +: 8];
            end
        end
    end
endmodule

// File: tb/tb_l1_latency_memory_module.sv
// Directed bench: a 2/1-latency instance and a zero-latency instance, checked against a read scoreboard.
module tb_l1_latency_memory_module;
    logic        clk = 1'b0;
    logic        reset;
    logic        rd_en, wr_en, stall;
    logic [31:0] rd_addr, wr_addr, wr_data, rdata;
    logic [3:0]  wr_mask;
    logic        rd_en0, wr_en0, stall0;
    logic [31:0] rd_addr0, wr_addr0, wr_data0, rdata0;
    logic [3:0]  wr_mask0;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    l1_latency_memory_module #(.LOGICAL_ADD_WIDTH(12), .DATA_WIDTH(32),
                               .READ_LATENCY(2), .WRITE_LATENCY(1)) dut (
        .clk(clk), .reset(reset), .read_en(rd_en), .read_addr(rd_addr),
        .write_en(wr_en), .write_addr(wr_addr), .write_mask(wr_mask),
        .write_data(wr_data), .read_data(rdata), .stall(stall));

    l1_latency_memory_module #(.LOGICAL_ADD_WIDTH(12), .DATA_WIDTH(32),
                               .READ_LATENCY(0), .WRITE_LATENCY(0)) dut0 (
        .clk(clk), .reset(reset), .read_en(rd_en0), .read_addr(rd_addr0),
        .write_en(wr_en0), .write_addr(wr_addr0), .write_mask(wr_mask0),
        .write_data(wr_data0), .read_data(rdata0), .stall(stall0));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Counts stall cycles up to the completion cycle, then checks any scoreboarded read.
    task automatic wait_done(input int exp_st, input logic is_rd, input string tag);
        int  n    = 0;
        bit  done = 1'b0;
        logic [31:0] e;
        for (int i = 0; i < 16 && !done; i++) begin
            @(negedge clk);
            if (stall) n++;
            else done = 1'b1;
        end
        chk({tag, "_stall"}, 32'(n), 32'(exp_st));
        if (is_rd) begin
            e = exp_q.pop_front();
            chk({tag, "_data"}, rdata, e);
        end
        @(posedge clk); #1;
        rd_en = 1'b0; wr_en = 1'b0; wr_mask = 4'h0;
    endtask

    task automatic do_req(input logic r, input logic [31:0] ra, input logic [31:0] exp_rd,
                          input logic w, input logic [31:0] wa, input logic [3:0] m,
                          input logic [31:0] wd, input int exp_st, input string tag);
        rd_en = r; rd_addr = ra; wr_en = w; wr_addr = wa; wr_mask = m; wr_data = wd;
        if (r) exp_q.push_back(exp_rd);
        wait_done(exp_st, r, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] e;
        reset = 1'b1;
        rd_en = 0; wr_en = 0; rd_addr = 0; wr_addr = 0; wr_mask = 0; wr_data = 0;
        rd_en0 = 0; wr_en0 = 0; rd_addr0 = 0; wr_addr0 = 0; wr_mask0 = 0; wr_data0 = 0;
        repeat (2) @(negedge clk);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_rdata0", rdata0, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Preload through the write port.
        do_req(0, 0, 0, 1, 32'h10, 4'hF, 32'hDEADBEEF, 1, "init10");
        do_req(0, 0, 0, 1, 32'h20, 4'hF, 32'h11223344, 1, "init20");
        do_req(0, 0, 0, 1, 32'h40, 4'hF, 32'h0BADF00D, 1, "init40");

        do_req(1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 2, "rd10");
        @(negedge clk);
        chk("rd10_hold", rdata, 32'hDEADBEEF);
        @(posedge clk); #1;

        do_req(0, 0, 0, 1, 32'h20, 4'b0101, 32'hAABBCCDD, 1, "wrmask");
        do_req(1, 32'h20, 32'h11BB33DD, 0, 0, 0, 0, 2, "rdmask");

`ifdef L1_MEM_RDW_BYPASS_EN
        e = 32'hFFFFFFFF;
`else
        e = 32'h11BB33DD;
`endif
        do_req(1, 32'h20, e, 1, 32'h20, 4'hF, 32'hFFFFFFFF, 2, "rdw");
        do_req(1, 32'h20, 32'hFFFFFFFF, 0, 0, 0, 0, 2, "rdw_after");

        do_req(0, 0, 0, 1, 32'h10, 4'h0, 32'h00000000, 1, "wr_nomask");
        do_req(1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 2, "rd_nomask");

        // Inputs changing while busy must be ignored.
        rd_en = 1'b1; rd_addr = 32'h10; exp_q.push_back(32'hDEADBEEF);
        @(posedge clk); #1;
        rd_addr = 32'h20;
        wait_done(1, 1'b1, "latched");

        do_req(0, 0, 0, 1, 32'h1004, 4'hF, 32'hCAFEF00D, 1, "wralias");
        do_req(1, 32'h0004, 32'hCAFEF00D, 0, 0, 0, 0, 2, "rdalias");

        // Reset during the first busy cycle of a write.
        wr_en = 1'b1; wr_addr = 32'h40; wr_mask = 4'hF; wr_data = 32'h12345678;
        @(negedge clk);
        chk("midrst_pre_stall", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b1; wr_en = 1'b0; wr_mask = 4'h0;
        #1;
        chk("midrst_stall", {31'd0, stall}, 32'd0);
        chk("midrst_rdata", rdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        do_req(1, 32'h40, 32'h0BADF00D, 0, 0, 0, 0, 2, "rd40_after_rst");

        // Zero-latency instance: back-to-back writes then reads, no stall at all.
        for (int i = 0; i < 4; i++) begin
            wr_en0 = 1'b1; wr_addr0 = 32'(4 * i); wr_mask0 = 4'hF; wr_data0 = 32'hA0000000 + 32'(i);
            @(negedge clk);
            chk("l0_wr_stall", {31'd0, stall0}, 32'd0);
            @(posedge clk); #1;
        end
        wr_en0 = 1'b0; wr_mask0 = 4'h0;
        for (int i = 0; i < 4; i++) begin
            rd_en0 = 1'b1; rd_addr0 = 32'(4 * i);
            exp_q.push_back(32'hA0000000 + 32'(i));
            @(negedge clk);
            chk("l0_rd_stall", {31'd0, stall0}, 32'd0);
            e = exp_q.pop_front();
            chk("l0_rd_data", rdata0, e);
            @(posedge clk); #1;
        end
        rd_en0 = 1'b0;
        @(negedge clk);
        chk("l0_hold", rdata0, 32'hA0000003);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
